// File: rtl/signed_bcd_conv.sv
// Multi-cycle two's-complement to packed-BCD converter using double dabble.
// Produces sign, BCD magnitude and significant digit count for a 7-seg driver.
module signed_bcd_conv #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  uclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [3:0]            ndigits
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic [3:0]            ndig_q, ndig_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   adj;
  logic [3:0]            lead;

  // Add-3 correction applied to every scratch digit before the shift
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                            scratch_q[4*gi +: 4] + 4'd3 : scratch_q[4*gi +: 4];
  end

  always_comb begin
    lead = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] != 4'd0) lead = 4'(i + 1);
    end
  end

  always_ff @(posedge uclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ndig_d    = ndig_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d     = value[WIDTH-1];
          // Unsigned negate, so the most negative input maps to 2^(WIDTH-1)
          mag_d     = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        {scratch_d, mag_d} = {adj, mag_q} << 1;
        cnt_d              = cnt_q + CW'(1);
      end
      FINISH: begin
        bcd_d  = scratch_q;
        ndig_d = lead;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge uclk) begin
    if (rst) begin
      cnt_q     <= '0;
      mag_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ndig_q    <= 4'd1;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ndig_q    <= ndig_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign neg     = neg_q;
  assign ndigits = ndig_q;

endmodule
